// File: rtl/door_pkg.sv
// Shared types and defaults for the timed door controller.
package door_pkg;

   localparam int ST_W              = 3;
   localparam int HOLD_CYCLES_DEF   = 16;
   localparam int MOTOR_TIMEOUT_DEF = 64;

   typedef enum logic [ST_W-1:0] {
      ST_CLOSED    = 3'd0,
      ST_OPENING   = 3'd1,
      ST_OPEN_HOLD = 3'd2,
      ST_CLOSING   = 3'd3,
      ST_STOP      = 3'd4,
      ST_FAULT     = 3'd5
   } door_state_t;

endpackage

// File: rtl/door_ctrl_timed_if.sv
// Pin-side bundle of the door controller: enable, sensors, limits and
// motor/status outputs. master drives the sensors, slave is the controller.
interface door_ctrl_timed_if #(
   parameter int CNT_W = 8
);
   import door_pkg::*;

   logic             ena;
   logic             sen;
   logic             se;
   logic             la;
   logic             lc;
   logic             ma;
   logic             mc;
   logic [ST_W-1:0]  state;
   logic             fault;
   logic [CNT_W-1:0] rev_cnt;

   modport master (
      output ena, sen, se, la, lc,
      input  ma, mc, state, fault, rev_cnt
   );

   modport slave (
      input  ena, sen, se, la, lc,
      output ma, mc, state, fault, rev_cnt
   );

endinterface

// File: rtl/door_timer.sv
// Loadable down-counter shared by the hold and motor-travel timeouts.
module door_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // Load has priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/door_ctrl_timed.sv
// Timed single-door controller: hold-open auto-close, obstruction reversal,
// travel watchdog with latched fault, emergency stop, reversal counter.
// Optional macro DOOR_INPUT_SYNC_EN adds two-flop synchronisers on
// sen/se/la/lc (adds two cycles of input latency).
module door_ctrl_timed
   import door_pkg::*;
#(
   parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
   parameter int MOTOR_TIMEOUT = MOTOR_TIMEOUT_DEF,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   door_ctrl_timed_if.slave bus
);

   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] MOTOR_LOAD = CNT_W'(MOTOR_TIMEOUT - 1);

   logic sen, se, la, lc;

`ifdef DOOR_INPUT_SYNC_EN
   logic [3:0] sync_q1, sync_q2;

   // Two-flop synchronisers for the asynchronous sensor and switch inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= {bus.sen, bus.se, bus.la, bus.lc};
         sync_q2 <= sync_q1;
      end
   end

   assign {sen, se, la, lc} = sync_q2;
`else
   assign sen = bus.sen;
   assign se  = bus.se;
   assign la  = bus.la;
   assign lc  = bus.lc;
`endif

   door_state_t      st, nxt;
   logic [CNT_W-1:0] rev_cnt;
   logic             t_load, t_dec, t_zero, rev_inc;
   logic [CNT_W-1:0] t_val;
   logic             illegal;

   assign illegal = (st > ST_FAULT);

   door_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (bus.ena & t_load),
      .load_val (t_val),
      .dec      (bus.ena & t_dec),
      .zero     (t_zero)
   );

   // Next-state and timer control; fault, limit conflict and e-stop take
   // priority over the per-state rules.
   always_comb begin
      nxt     = st;
      t_load  = 1'b0;
      t_val   = '0;
      t_dec   = 1'b0;
      rev_inc = 1'b0;
      if ((st == ST_FAULT) || illegal) begin
         nxt = ST_FAULT;
      end else if (la && lc) begin
         nxt = ST_FAULT;
      end else if (se) begin
         nxt = ST_STOP;
      end else begin
         case (st)
            ST_CLOSED: begin
               if (sen) begin
                  nxt    = ST_OPENING;
                  t_load = 1'b1;
                  t_val  = MOTOR_LOAD;
               end
            end
            ST_OPENING: begin
               if (la) begin
                  nxt    = ST_OPEN_HOLD;
                  t_load = 1'b1;
                  t_val  = HOLD_LOAD;
               end else if (t_zero) begin
                  nxt = ST_FAULT;
               end else begin
                  t_dec = 1'b1;
               end
            end
            ST_OPEN_HOLD: begin
               if (sen) begin
                  t_load = 1'b1;
                  t_val  = HOLD_LOAD;
               end else if (t_zero) begin
                  nxt    = ST_CLOSING;
                  t_load = 1'b1;
                  t_val  = MOTOR_LOAD;
               end else begin
                  t_dec = 1'b1;
               end
            end
            ST_CLOSING: begin
               if (sen) begin
                  nxt     = ST_OPENING;
                  t_load  = 1'b1;
                  t_val   = MOTOR_LOAD;
                  rev_inc = 1'b1;
               end else if (lc) begin
                  nxt = ST_CLOSED;
               end else if (t_zero) begin
                  nxt = ST_FAULT;
               end else begin
                  t_dec = 1'b1;
               end
            end
            ST_STOP: begin
               // se is already low here: resume toward the nearest safe end.
               if (la) begin
                  nxt    = ST_OPEN_HOLD;
                  t_load = 1'b1;
                  t_val  = HOLD_LOAD;
               end else if (lc) begin
                  nxt = ST_CLOSED;
               end else begin
                  nxt    = ST_OPENING;
                  t_load = 1'b1;
                  t_val  = MOTOR_LOAD;
               end
            end
            default: nxt = ST_FAULT;
         endcase
      end
   end

   // State register and saturating reversal counter; both hold while ena=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= ST_CLOSED;
         rev_cnt <= '0;
      end else if (bus.ena) begin
         st <= nxt;
         if (rev_inc && (rev_cnt != '1)) begin
            rev_cnt <= rev_cnt + 1'b1;
         end
      end
   end

   assign bus.ma      = bus.ena & (st == ST_OPENING);
   assign bus.mc      = bus.ena & (st == ST_CLOSING);
   assign bus.fault   = (st == ST_FAULT);
   assign bus.state   = st;
   assign bus.rev_cnt = rev_cnt;

endmodule

// File: tb/tb_door_ctrl_timed.sv
// Scoreboard bench for door_ctrl_timed with HOLD_CYCLES=4, MOTOR_TIMEOUT=8.
module tb_door_ctrl_timed;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   door_ctrl_timed_if #(.CNT_W(8)) bus ();

   door_ctrl_timed #(
      .HOLD_CYCLES   (4),
      .MOTOR_TIMEOUT (8),
      .CNT_W         (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic       ma;
      logic       mc;
      logic       flt;
      logic [7:0] rev;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   erev    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs on negedge, queue the expectation, compare after posedge.
   task automatic cyc(input string tag, input logic r, input logic e, input logic s,
                      input logic stp, input logic a, input logic c, input logic [2:0] est);
      exp_t x, y;
      @(negedge clk);
      rst     = r;
      bus.ena = e;
      bus.sen = s;
      bus.se  = stp;
      bus.la  = a;
      bus.lc  = c;
      if (r) erev = 0;
      x.tag = tag;
      x.st  = est;
      x.ma  = e & (est == 3'd1);
      x.mc  = e & (est == 3'd3);
      x.flt = (est == 3'd5);
      x.rev = 8'(erev);
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         y = exp_q.pop_front();
         chk({y.tag, ".state"}, 32'(bus.state), 32'(y.st));
         chk({y.tag, ".ma"}, 32'(bus.ma), 32'(y.ma));
         chk({y.tag, ".mc"}, 32'(bus.mc), 32'(y.mc));
         chk({y.tag, ".fault"}, 32'(bus.fault), 32'(y.flt));
         chk({y.tag, ".rev"}, 32'(bus.rev_cnt), 32'(y.rev));
      end
      rst = 1'b0;
   endtask

   // Idle enabled cycle with all sensors low.
   task automatic idle(input string tag, input logic [2:0] est);
      cyc(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, est);
   endtask

   initial begin
      bus.ena = 1'b1;
      bus.sen = 1'b0;
      bus.se  = 1'b0;
      bus.la  = 1'b0;
      bus.lc  = 1'b0;

      // Reset and normal open/hold/close cycle
      cyc("reset", 1, 1, 0, 0, 0, 0, 3'd0);
      cyc("open_req", 0, 1, 1, 0, 0, 0, 3'd1);
      idle("opening", 3'd1);
      cyc("at_open", 0, 1, 0, 0, 1, 0, 3'd2);
      for (int i = 0; i < 3; i++) cyc("hold", 0, 1, 0, 0, 1, 0, 3'd2);
      idle("auto_close", 3'd3);
      cyc("at_closed", 0, 1, 0, 0, 0, 1, 3'd0);

      // Hold extension by a presence pulse on the third hold cycle
      cyc("ext_open", 0, 1, 1, 0, 0, 0, 3'd1);
      cyc("ext_la", 0, 1, 0, 0, 1, 0, 3'd2);
      idle("ext_h1", 3'd2);
      idle("ext_h2", 3'd2);
      cyc("ext_pulse", 0, 1, 1, 0, 0, 0, 3'd2);
      for (int i = 0; i < 3; i++) idle("ext_hold", 3'd2);
      idle("ext_close", 3'd3);

      // Reversals with saturation; the first one also has lc high (sen wins)
      for (int i = 0; i < 300; i++) begin
         erev = (erev < 255) ? erev + 1 : 255;
         cyc("rev", 0, 1, 1, 0, 0, (i == 0), 3'd1);
         cyc("rev_la", 0, 1, 0, 0, 1, 0, 3'd2);
         for (int j = 0; j < 3; j++) idle("rev_hold", 3'd2);
         idle("rev_close", 3'd3);
      end
      cyc("rev_done", 0, 1, 0, 0, 0, 1, 3'd0);

      // Watchdog on OPENING, then fault is absorbing until reset
      cyc("wd_open", 0, 1, 1, 0, 0, 0, 3'd1);
      for (int i = 0; i < 7; i++) idle("wd_travel", 3'd1);
      idle("wd_fault", 3'd5);
      cyc("wd_abs_se", 0, 1, 1, 1, 0, 0, 3'd5);
      cyc("wd_abs_sen", 0, 1, 1, 0, 0, 0, 3'd5);
      idle("wd_abs_idle", 3'd5);
      cyc("wd_reset", 1, 1, 0, 0, 0, 0, 3'd0);

      // Emergency stop and the three release paths
      cyc("es_open", 0, 1, 1, 0, 0, 0, 3'd1);
      cyc("es_la", 0, 1, 0, 0, 1, 0, 3'd2);
      for (int i = 0; i < 3; i++) idle("es_hold", 3'd2);
      idle("es_closing", 3'd3);
      cyc("es_stop", 0, 1, 0, 1, 0, 0, 3'd4);
      cyc("es_stay", 0, 1, 0, 1, 0, 0, 3'd4);
      idle("es_rel_mid", 3'd1);
      cyc("es_stop2", 0, 1, 0, 1, 0, 0, 3'd4);
      cyc("es_rel_la", 0, 1, 0, 0, 1, 0, 3'd2);
      cyc("es_stop3", 0, 1, 0, 1, 0, 0, 3'd4);
      cyc("es_rel_lc", 0, 1, 0, 0, 0, 1, 3'd0);

      // Reset mid-travel ignores limits; inconsistent limits fault
      cyc("mid_open", 0, 1, 1, 0, 0, 0, 3'd1);
      cyc("mid_reset", 1, 1, 0, 0, 1, 0, 3'd0);
      cyc("lim_bad", 0, 1, 0, 0, 1, 1, 3'd5);
      cyc("lim_reset", 1, 1, 0, 0, 0, 0, 3'd0);

      // Enable low mid-travel freezes state and timer
      cyc("en_open", 0, 1, 1, 0, 0, 0, 3'd1);
      for (int i = 0; i < 10; i++) cyc("en_low", 0, 0, 0, 0, 0, 0, 3'd1);
      for (int i = 0; i < 7; i++) idle("en_resume", 3'd1);
      cyc("en_arrive", 0, 1, 0, 0, 1, 0, 3'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/door_ctrl_timed.md
Name: door_ctrl_timed

Overview:
- Parametrised successor to the team's single-door open/close FSM.
- Drives open/close motor enables from a presence sensor, an emergency-stop input and two limit switches.
- Adds features the first generation lacks: a hold-open timer with auto-close, obstruction reversal while closing, a motor-travel watchdog with latched fault, an emergency-stop state, and a saturating reversal counter.
- Sits directly behind the chip-level pin wrapper. Inputs come from ui pins; outputs go to uo pins.

Parameters:
- HOLD_CYCLES, 16: cycles the door stays fully open with no presence before auto-close; must be ≥1.
- MOTOR_TIMEOUT, 64: maximum cycles allowed in OPENING or CLOSING before FAULT; must be ≥1.
- CNT_W, 8: width of the internal timer and of rev_cnt; must hold max(HOLD_CYCLES, MOTOR_TIMEOUT).

Ports:
- clk, input, 1: single clock.
- rst, input, 1: reset, synchronous and active-high.
- ena, input, 1: advance enable. When low, state, timer and rev_cnt hold.
- sen, input, 1: presence sensor.
- se, input, 1: emergency stop.
- la, input, 1: open limit switch.
- lc, input, 1: closed limit switch.
- ma, output, 1: open-motor enable.
- mc, output, 1: close-motor enable.
- state, output, 3: current state code.
- fault, output, 1: high while in FAULT.
- rev_cnt, output, CNT_W: saturating count of close-to-open reversals.

Behaviour:
- Reset (rst=1 at a clk edge): state=CLOSED, timer=0, rev_cnt=0. This gives ma=0, mc=0, fault=0 from the following cycle.
- States and codes: CLOSED=0, OPENING=1, OPEN_HOLD=2, CLOSING=3, STOP=4, FAULT=5. Codes 6 and 7 are illegal and go to FAULT on the next enabled edge.
- Output decode (combinational from the state register, gated by ena):
  - ma = ena & (state==OPENING)
  - mc = ena & (state==CLOSING)
  - fault = (state==FAULT), not gated
- Latency: a response to an input appears on ma/mc exactly one enabled clk edge later.
- Next-state priority, evaluated on every edge with ena=1:
  1. FAULT is absorbing. Only rst leaves it.
  2. la & lc both high (inconsistent limits) → FAULT, from any state.
  3. se high → STOP, from any state.
  4. Per-state rules below.
- CLOSED: sen=1 → OPENING, timer loaded with MOTOR_TIMEOUT-1. Otherwise stay.
- OPENING:
  - la=1 → OPEN_HOLD, timer loaded with HOLD_CYCLES-1.
  - else timer==0 → FAULT.
  - else timer decrements.
- OPEN_HOLD:
  - sen=1 → stay, timer reloaded with HOLD_CYCLES-1.
  - else timer==0 → CLOSING, timer loaded with MOTOR_TIMEOUT-1.
  - else timer decrements.
  - With sen held low, the door spends exactly HOLD_CYCLES enabled cycles in OPEN_HOLD.
- CLOSING:
  - sen=1 → OPENING, timer loaded with MOTOR_TIMEOUT-1, rev_cnt increments (saturates at all-ones).
  - else lc=1 → CLOSED.
  - else timer==0 → FAULT.
  - else timer decrements.
  - If sen and lc are high in the same cycle, sen wins and the door reverses.
- STOP:
  - Motors are off.
  - While se=1, stay.
  - On se=0: la=1 → OPEN_HOLD (timer loaded with HOLD_CYCLES-1); else lc=1 → CLOSED; else → OPENING (timer loaded with MOTOR_TIMEOUT-1). Opening is the fail-safe choice.
- ena low in OPENING or CLOSING: motors off, timer frozen. Travel resumes from the same timer value when ena returns.
- Reset asserted mid-travel: forces CLOSED on that edge regardless of the limit switches.

Optional Feature:
- Macro: DOOR_INPUT_SYNC_EN.
- Defined: sen, se, la and lc each pass through a two-flop synchroniser clocked by clk and cleared to 0 by rst. All input-to-output latency grows by 2 cycles.
- Undefined: inputs are used directly, with 1-cycle latency as specified above.

Decomposition:
- Package door_pkg holds:
  - the 3-bit state typedef/enumeration with the codes above
  - constants ST_W=3 and the default HOLD_CYCLES/MOTOR_TIMEOUT values
- Sub-module door_timer: a CNT_W-bit down-counter with load, load_val, dec and a zero flag. It is instantiated once, and the FSM drives load/dec.
- The optional synchronisers stay inline under the macro.

Test Plan (HOLD_CYCLES=4, MOTOR_TIMEOUT=8, macro undefined):
- Normal cycle:
  - rst, then sen=1 for 1 cycle → state=1 and ma=1 one cycle later.
  - la=1 → state=2, ma=0. Hold for exactly 4 cycles, then state=3 and mc=1.
  - lc=1 → state=0.
- Hold extension: in OPEN_HOLD, pulse sen at cycle 3 → CLOSING begins 4 cycles after the pulse, not after the original expiry.
- Reversal: in CLOSING, sen=1 → state=1 with rev_cnt=1. Repeat 300 reversals → rev_cnt saturates at 255.
- Watchdog: in OPENING, hold la=0 → state=5 and fault=1 exactly 8 cycles after entry. se/sen toggles are then ignored; rst returns state to 0.
- Emergency stop: se=1 mid-CLOSING → state=4, mc=0. Release with la=0, lc=0 → state=1.
- Inconsistent limits and enable:
  - la=lc=1 in CLOSED → state=5.
  - Separately, ena=0 mid-OPENING for 10 cycles → ma=0, no FAULT; travel completes after ena returns to 1.
